// File: rtl/pwm_ccr_out.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ccr_out
// Description : Shadowed compare register and H-bridge PWM leg driver.
//               Requested duty/direction are captured in a shadow register
//               and applied at period boundaries (E). A direction reversal
//               inserts DEAD_PERIODS full periods with both legs low.
//               Optional macro RAMP_EN: limits the change of CCR to
//               RAMP_STEP per boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_ccr_out #(
  parameter int DEAD_PERIODS = 2,
  parameter int RAMP_STEP    = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] TCR,
  input  logic       E,
  input  logic [6:0] DUTY,
  input  logic       DIR,
  input  logic       LOAD,
  output logic       PWM_A,
  output logic       PWM_B,
  output logic [6:0] CCR,
  output logic [1:0] STATE,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_BRAKE = 2'b10
  } state_t;

  // Counter preload: brake entered at boundary k exits at k+DEAD_PERIODS.
  localparam logic [3:0] c_dead_init = 4'(DEAD_PERIODS - 1);

  // Reject out-of-range parameters at elaboration.
  if (DEAD_PERIODS < 1 || DEAD_PERIODS > 15) begin : g_bad_dead_periods
    $error("pwm_ccr_out: DEAD_PERIODS must be 1..15");
  end
  if (RAMP_STEP < 1 || RAMP_STEP > 127) begin : g_bad_ramp_step
    $error("pwm_ccr_out: RAMP_STEP must be 1..127");
  end

  state_t     r_state;
  logic [6:0] r_ccr;
  logic       r_dir_act;
  logic [6:0] r_duty_sh;
  logic       r_dir_sh;
  logic       r_pend;
  logic [3:0] r_dead;
  logic       r_pwm_a;
  logic       r_pwm_b;

  state_t     w_state_nxt;
  logic [6:0] w_ccr_nxt;
  logic       w_dir_nxt;
  logic       w_pend_nxt;
  logic [3:0] w_dead_nxt;
  logic       w_apply;
  logic [6:0] w_step_ccr;
  logic       w_on;

`ifdef RAMP_EN
  localparam logic [6:0] c_ramp_step = 7'(RAMP_STEP);

  // Move the current value toward the target by at most c_ramp_step.
  function automatic logic [6:0] approach(input logic [6:0] cur, input logic [6:0] tgt);
    if (tgt > cur) begin
      return ((tgt - cur) > c_ramp_step) ? (cur + c_ramp_step) : tgt;
    end else begin
      return ((cur - tgt) > c_ramp_step) ? (cur - c_ramp_step) : tgt;
    end
  endfunction
`endif

  // Boundary decisions: apply shadow, enter brake, or count down the brake.
  always_comb begin
    w_state_nxt = r_state;
    w_ccr_nxt   = r_ccr;
    w_dir_nxt   = r_dir_act;
    w_pend_nxt  = r_pend;
    w_dead_nxt  = r_dead;
    w_apply     = 1'b0;
`ifdef RAMP_EN
    w_step_ccr  = approach(r_ccr, r_duty_sh);
`else
    w_step_ccr  = r_duty_sh;
`endif

    if (E && r_pend) begin
      case (r_state)
        S_IDLE: w_apply = 1'b1;
        S_RUN: begin
          if (r_dir_sh == r_dir_act) begin
            w_apply = 1'b1;
          end else begin
            // Reversal: drop both legs and hold for the dead interval.
            w_ccr_nxt   = 7'd0;
            w_state_nxt = S_BRAKE;
            w_dead_nxt  = c_dead_init;
          end
        end
        S_BRAKE: begin
          if (r_dead != 4'd0) begin
            w_dead_nxt = r_dead - 4'd1;
          end else begin
            w_apply = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // CCR is 0 throughout BRAKE, so a ramp after brake starts from 0.
    if (w_apply) begin
      w_ccr_nxt   = w_step_ccr;
      w_dir_nxt   = r_dir_sh;
      w_state_nxt = (w_step_ccr != 7'd0) ? S_RUN : S_IDLE;
      w_pend_nxt  = (w_step_ccr != r_duty_sh);
    end
  end

  // Compare uses the post-update CCR so the new duty covers TCR==0.
  always_comb begin
    w_on = (TCR < w_ccr_nxt) && (w_state_nxt == S_RUN);
  end

  // State, compare register, shadow capture and registered leg outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_ccr     <= 7'd0;
      r_dir_act <= 1'b0;
      r_duty_sh <= 7'd0;
      r_dir_sh  <= 1'b0;
      r_pend    <= 1'b0;
      r_dead    <= 4'd0;
      r_pwm_a   <= 1'b0;
      r_pwm_b   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ccr     <= w_ccr_nxt;
      r_dir_act <= w_dir_nxt;
      r_dead    <= w_dead_nxt;
      r_pwm_a   <= w_on & ~w_dir_nxt;
      r_pwm_b   <= w_on & w_dir_nxt;
      // A LOAD coincident with a boundary is captured after the boundary
      // has consumed the previous shadow, and leaves a new request pending.
      if (LOAD) begin
        r_duty_sh <= DUTY;
        r_dir_sh  <= DIR;
        r_pend    <= 1'b1;
      end else begin
        r_pend    <= w_pend_nxt;
      end
    end
  end

  assign PWM_A = r_pwm_a;
  assign PWM_B = r_pwm_b;
  assign CCR   = r_ccr;
  assign STATE = r_state;
  assign BUSY  = r_pend || (r_state == S_BRAKE);

endmodule
`default_nettype wire

// File: tb/tb_pwm_ccr_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_ccr_out
// Description : Directed self-checking bench for pwm_ccr_out. The bench acts
//               as the timer (TCR/E) and checks hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_ccr_out;

  logic       CLK = 1'b0;
  logic       RST;
  logic [6:0] TCR;
  logic       E;
  logic [6:0] DUTY;
  logic       DIR;
  logic       LOAD;
  logic       PWM_A;
  logic       PWM_B;
  logic [6:0] CCR;
  logic [1:0] STATE;
  logic       BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_ccr_out #(.DEAD_PERIODS(2), .RAMP_STEP(8)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .TCR   (TCR),
    .E     (E),
    .DUTY  (DUTY),
    .DIR   (DIR),
    .LOAD  (LOAD),
    .PWM_A (PWM_A),
    .PWM_B (PWM_B),
    .CCR   (CCR),
    .STATE (STATE),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample point is #1 after the edge, then drive next timer value.
  task automatic tick();
    @(posedge CLK);
    #1;
    TCR = TCR + 7'd1;
    E   = (TCR == 7'd0);
  endtask

  task automatic goto_tcr(input logic [6:0] v);
    for (int i = 0; i < 130 && TCR != v; i++) tick();
  endtask

  task automatic load_cmd(input logic [6:0] d, input logic dr);
    DUTY = d;
    DIR  = dr;
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
  endtask

  // Afterwards the outputs reflect the boundary edge (TCR==0 sampled).
  task automatic cross_boundary();
    goto_tcr(7'd0);
    tick();
  endtask

  task automatic count_period(output int ca, output int cb, output int cboth);
    ca = 0; cb = 0; cboth = 0;
    for (int i = 0; i < 128; i++) begin
      ca    += int'(PWM_A);
      cb    += int'(PWM_B);
      cboth += int'(PWM_A & PWM_B);
      tick();
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick(); tick(); tick();
    RST = 1'b0;
  endtask

  int ca, cb, cboth, n_brake, n_legs;

  initial begin
    TCR = 7'd5; E = 1'b0; DUTY = 7'd0; DIR = 1'b0; LOAD = 1'b0; RST = 1'b1;
    do_reset();
    check("rst_pwm_a", PWM_A, 0);
    check("rst_pwm_b", PWM_B, 0);
    check("rst_ccr",   CCR,   0);
    check("rst_state", STATE, 0);
    check("rst_busy",  BUSY,  0);

`ifndef RAMP_EN
    // Forward 40 loaded mid-period.
    goto_tcr(7'd50);
    load_cmd(7'd40, 1'b0);
    check("t1_busy_pend", BUSY, 1);
    check("t1_ccr_held",  CCR,  0);
    cross_boundary();
    check("t1_ccr",   CCR,   40);
    check("t1_state", STATE, 1);
    check("t1_busy",  BUSY,  0);
    count_period(ca, cb, cboth);
    check("t1_a_high", ca, 40);
    check("t1_b_high", cb, 0);

    // Duty 0 while running.
    goto_tcr(7'd60);
    load_cmd(7'd0, 1'b0);
    cross_boundary();
    check("t2_ccr",   CCR,   0);
    check("t2_state", STATE, 0);
    check("t2_pwm_a", PWM_A, 0);
    count_period(ca, cb, cboth);
    check("t2_a_high", ca, 0);

    // Forward 64, then reverse to 100 through a 2-period brake.
    goto_tcr(7'd20);
    load_cmd(7'd64, 1'b0);
    cross_boundary();
    check("t3_ccr64", CCR, 64);
    goto_tcr(7'd30);
    load_cmd(7'd100, 1'b1);
    cross_boundary();
    check("t3_state_brake", STATE, 2);
    check("t3_ccr_brake",   CCR,   0);
    check("t3_busy_brake",  BUSY,  1);
    n_brake = 0; n_legs = 0;
    while (STATE == 2'd2 && n_brake < 400) begin
      n_legs += int'(PWM_A | PWM_B);
      n_brake++;
      tick();
    end
    check("t3_brake_cycles", n_brake, 256);
    check("t3_brake_legs",   n_legs,  0);
    check("t3_state_run",    STATE,   1);
    check("t3_ccr100",       CCR,     100);
    check("t3_busy_done",    BUSY,    0);
    count_period(ca, cb, cboth);
    check("t3_b_high", cb, 100);
    check("t3_a_high", ca, 0);
    check("t3_both",   cboth, 0);

    // LOAD coincident with E: boundary uses older shadow (90).
    goto_tcr(7'd70);
    load_cmd(7'd90, 1'b1);
    goto_tcr(7'd0);
    load_cmd(7'd20, 1'b1);
    check("t4_ccr90",    CCR,  90);
    check("t4_busy_pend", BUSY, 1);
    cross_boundary();
    check("t4_ccr20", CCR,  20);
    check("t4_busy",  BUSY, 0);

    // Reset while braking, then a reverse load applies with no brake.
    goto_tcr(7'd10);
    load_cmd(7'd50, 1'b0);
    cross_boundary();
    check("t5_state_brake", STATE, 2);
    for (int i = 0; i < 5; i++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t5_rst_state", STATE, 0);
    check("t5_rst_ccr",   CCR,   0);
    check("t5_rst_pwm",   int'({PWM_A, PWM_B}), 0);
    check("t5_rst_busy",  BUSY,  0);
    goto_tcr(7'd40);
    load_cmd(7'd10, 1'b1);
    cross_boundary();
    check("t5_state", STATE, 1);
    check("t5_ccr",   CCR,   10);
    count_period(ca, cb, cboth);
    check("t5_b_high", cb, 10);
    check("t5_a_high", ca, 0);
    cross_boundary();
    check("t5_no_pend_ccr", CCR, 10);
`else
    // Ramp from IDLE to 30 in steps of 8.
    goto_tcr(7'd50);
    load_cmd(7'd30, 1'b0);
    cross_boundary();
    check("r_ccr8",  CCR,   8);
    check("r_state", STATE, 1);
    check("r_busy8", BUSY,  1);
    cross_boundary();
    check("r_ccr16",  CCR,  16);
    check("r_busy16", BUSY, 1);
    cross_boundary();
    check("r_ccr24",  CCR,  24);
    check("r_busy24", BUSY, 1);
    cross_boundary();
    check("r_ccr30",  CCR,  30);
    check("r_busy30", BUSY, 0);
    count_period(ca, cb, cboth);
    check("r_a_high", ca, 30);
    check("r_b_high", cb, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
